i2s_mic_rx: RTL

Master-mode I2S receiver for a 24-bit MEMS microphone such as the INMP441. It generates SCK and WS, deserialises the selected channel and truncates each sample to its upper 16 bits. It writes one sample per frame into the downstream 128x16 mic sample FIFO through that FIFO's wr_en/din/full interface. It sits directly upstream of the mic buffer.

---
 rtl/i2s_mic_rx_if.sv | 10 +
 rtl/i2s_mic_rx.sv | 99 +++++++++
 2 files changed

// File: rtl/i2s_mic_rx_if.sv
// Write-side connection from the I2S mic receiver into the downstream mic sample FIFO.
// The receiver takes the master modport; the FIFO (or its stand-in) takes the slave modport.
interface i2s_mic_rx_if;
  logic        fifo_full;
  logic [15:0] sample_out;
  logic        sample_wr;

  modport master (input fifo_full, output sample_out, output sample_wr);
  modport slave  (output fifo_full, input sample_out, input sample_wr);
endinterface

// File: rtl/i2s_mic_rx.sv
// Master-mode I2S receiver for a 24-bit MEMS mic: drives SCK/WS, captures one slot per frame,
// keeps the upper 16 bits and writes them into the mic sample FIFO, counting drops when full.
module i2s_mic_rx #(
  parameter int CLK_DIV        = 4,
  parameter int CHANNEL        = 0,
  parameter int STARTUP_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         i2s_sd,
  output logic         i2s_sck,
  output logic         i2s_ws,
  output logic [7:0]   overflow_cnt,
  i2s_mic_rx_if.master fifo
);

  localparam int DATA_W = 16;
  localparam int DIV_W  = $clog2(CLK_DIV);

  logic [DIV_W-1:0]         div;
  logic                     sck;
  logic [5:0]               fb;
  logic [7:0]               frames_done;
  logic signed [DATA_W-1:0] shreg_p0;
  logic                     vld_p1;

  logic       div_end;
  logic       rise_stb;
  logic       fall_stb;
  logic       slot_act;
  logic [4:0] slot_bit;
  logic       startup_ok;
  logic       shift_en;
  logic       emit_p0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    div_end    = (div == DIV_W'(CLK_DIV - 1));
    rise_stb   = en && div_end && !sck;
    fall_stb   = en && div_end && sck;
    slot_bit   = fb[4:0];
    slot_act   = (fb[5] == 1'(CHANNEL));
    startup_ok = (frames_done == 8'(STARTUP_FRAMES));
    // Bit 0 of the slot is the I2S one-bit delay; the MSB arrives on bit 1.
    shift_en   = rise_stb && slot_act && (slot_bit >= 5'd1) && (slot_bit <= 5'd16);
    emit_p0    = rise_stb && slot_act && (slot_bit == 5'd16) && startup_ok;
  end

  assign i2s_sck = sck;
  assign i2s_ws  = fb[5];

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      div            <= '0;
      sck            <= 1'b0;
      fb             <= '0;
      frames_done    <= '0;
      shreg_p0       <= '0;
      vld_p1         <= 1'b0;
      fifo.sample_wr <= 1'b0;
      if (!rst) begin
        fifo.sample_out <= '0;
        overflow_cnt    <= '0;
      end
    end else begin
      if (div_end) begin
        div <= '0;
        sck <= ~sck;
      end else begin
        div <= div + 1'b1;
      end

      if (fall_stb) begin
        fb <= fb + 6'd1;
        if (fb == 6'd63 && !startup_ok)
          frames_done <= frames_done + 8'd1;
      end

      // p0: serial capture on the SCK rise, sd taken directly while the mic holds it stable
      if (shift_en)
        shreg_p0 <= {shreg_p0[DATA_W-2:0], i2s_sd};
      vld_p1 <= emit_p0;

      // p1: the complete word is in shreg_p0; fifo_full is judged on this cycle only
      fifo.sample_wr <= vld_p1 && !fifo.fifo_full;
      if (vld_p1) begin
        if (!fifo.fifo_full)
          fifo.sample_out <= shreg_p0;
        else
          overflow_cnt <= sat_inc(overflow_cnt);
      end
    end
  end

endmodule
